// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Wide enough for any practical DATA_W; the unit truncates it to its own width.
  localparam int unsigned DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between ID/EX operand delivery, the divider and writeback.
interface div_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  import div_pkg::*;

  logic              valid_i;
  logic              ready_o;
  div_op_e           op_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              kill_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] result_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              busy_o;

  modport master (
    output valid_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, rd_addr_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, rd_addr_o, busy_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            no_borrow;

  // A set top bit of the incoming remainder means the shifted value already exceeds any divisor.
  always_comb begin
    shifted   = {rem_in[DATA_W-1:0], quo_in[DATA_W-1]};
    diff      = shifted - {1'b0, divisor};
    no_borrow = rem_in[DATA_W] | ~diff[DATA_W];
    rem_out   = no_borrow ? diff : shifted;
    quo_out   = {quo_in[DATA_W-2:0], no_borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// skip the iterations and go straight to DONE on the accepting edge.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating, cnt_q counts completed steps
// DONE  | result valid, waiting for writeback
module div_unit import div_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e        state_q, state_d;
  div_op_e           op_q, op_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d, dvs_q, dvs_d, rs1_q, rs1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              zero_q, zero_d, ovf_q, ovf_d;

  logic [DATA_W:0]   step_rem;
  logic [DATA_W-1:0] step_quo;

  logic              is_signed, sign1, sign2, req_zero, req_ovf;
  logic [DATA_W-1:0] quo_fix, rem_fix, quo_res, rem_res;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Request decode: signedness, operand signs and the two architecturally defined special cases.
  always_comb begin
    is_signed = (bus.op_i == DIV) || (bus.op_i == REM);
    sign1     = is_signed & bus.rs1_data_i[DATA_W-1];
    sign2     = is_signed & bus.rs2_data_i[DATA_W-1];
    req_zero  = (bus.rs2_data_i == '0);
    req_ovf   = is_signed && (bus.rs1_data_i == MIN_NEG) && (bus.rs2_data_i == '1);
  end

  // Next-state and datapath update; kill overrides every other transition.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rs1_d     = rs1_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          op_d      = bus.op_i;
          rd_d      = bus.rd_addr_i;
          rs1_d     = bus.rs1_data_i;
          rem_d     = '0;
          quo_d     = sign1 ? -bus.rs1_data_i : bus.rs1_data_i;
          dvs_d     = sign2 ? -bus.rs2_data_i : bus.rs2_data_i;
          neg_quo_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          zero_d    = req_zero;
          ovf_d     = req_ovf;
          cnt_d     = '0;
          state_d   = CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (req_zero || req_ovf) state_d = DONE;
`else
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.kill_i) state_d = IDLE;
  end

  // Sign correction and special-case override of the final result.
  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
    quo_res = quo_fix;
    rem_res = rem_fix;
    if (zero_q) begin
      quo_res = DATA_W'(DIV_ZERO_Q);
      rem_res = rs1_q;
    end else if (ovf_q) begin
      quo_res = MIN_NEG;
      rem_res = '0;
    end
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.rd_addr_o = rd_q;
  assign bus.result_o  = (state_q != DONE) ? '0 :
                         ((op_q == REM) || (op_q == REMU)) ? rem_res : quo_res;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rs1_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rs1_q     <= rs1_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit.
module tb_div_unit;
  import div_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   pass_cnt = 0;
  int   total_cnt = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 32;
`endif

  div_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  div_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Presents one request at #1 after an edge, returns edges from the accepting edge to valid_o.
  task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat);
    bus.valid_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.valid_i = 1'b0; bus.op_i = DIV; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
    bus.rd_addr_i = '0; bus.kill_i = 1'b0; bus.ready_i = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    total_cnt++;
    if ({bus.valid_o, bus.busy_o, bus.result_o, bus.rd_addr_o} !== 39'd0)
      $display("FAIL reset_outputs: valid=%b busy=%b result=%h rd=%0d expected all 0",
               bus.valid_o, bus.busy_o, bus.result_o, bus.rd_addr_o);
    else pass_cnt++;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total_cnt++;
    if (bus.ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready_o);
    else pass_cnt++;
  endtask

  task automatic check_op(input string name, input div_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(op, a, b, rd, lat);
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== exp_res) $display("FAIL %s_result: got %h expected %h", name, bus.result_o, exp_res);
    else pass_cnt++;
    total_cnt++;
    if (bus.rd_addr_o !== rd) $display("FAIL %s_rd: got %0d expected %0d", name, bus.rd_addr_o, rd);
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_signed();
    check_op("div_7_m2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 32);
    check_op("rem_7_m2", REM, 32'h0000_0007, 32'hFFFF_FFFE, 5'd4, 32'h0000_0001, 32);
    check_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_unsigned();
    check_op("divu_max_16", DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd12, 32'h0FFF_FFFF, 32);
    check_op("remu_max_16", REMU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd12, 32'h0000_000F, 32);
  endtask

  task automatic test_div_zero();
    check_op("div_zero",  DIV,  32'h1234_5678, 32'h0, 5'd1,  32'hFFFF_FFFF, SPECIAL_LAT);
    check_op("rem_zero",  REM,  32'h1234_5678, 32'h0, 5'd2,  32'h1234_5678, SPECIAL_LAT);
    check_op("divu_zero", DIVU, 32'h8000_0001, 32'h0, 5'd30, 32'hFFFF_FFFF, SPECIAL_LAT);
    check_op("remn_zero", REM,  32'h8000_0001, 32'h0, 5'd31, 32'h8000_0001, SPECIAL_LAT);
  endtask

  task automatic test_overflow();
    check_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, SPECIAL_LAT);
    check_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, SPECIAL_LAT);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    bus.ready_i = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 5'd21, lat);
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd14 || bus.rd_addr_o !== 5'd21 || bus.ready_o !== 1'b0)
        bad++;
      @(posedge clk_i); #1;
    end
    total_cnt++;
    if (bad != 0 || lat != 32)
      $display("FAIL backpressure_hold: %0d unstable cycles, latency %0d, expected 0 and 32", bad, lat);
    else pass_cnt++;
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    total_cnt++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1)
      $display("FAIL backpressure_release: valid=%b ready=%b expected 0 1", bus.valid_o, bus.ready_o);
    else pass_cnt++;
  endtask

  task automatic test_kill();
    logic seen = 1'b0;
    bus.valid_i = 1'b1; bus.op_i = DIV; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd3; bus.rd_addr_i = 5'd6;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
    bus.kill_i = 1'b1;
    @(posedge clk_i); #1;
    bus.kill_i = 1'b0;
    total_cnt++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0)
      $display("FAIL kill_idle: ready=%b busy=%b expected 1 0", bus.ready_o, bus.busy_o);
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o) seen = 1'b1;
      @(posedge clk_i); #1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL kill_no_result: valid_o seen=%b expected 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.valid_i = 1'b1; bus.op_i = DIVU; bus.rs1_data_i = 32'd999; bus.rs2_data_i = 32'd9; bus.rd_addr_i = 5'd17;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if ({bus.valid_o, bus.busy_o, bus.result_o, bus.rd_addr_o} !== 39'd0 || bus.ready_o !== 1'b1)
      $display("FAIL reset_mid_outputs: valid=%b busy=%b ready=%b result=%h rd=%0d expected 0 0 1 0 0",
               bus.valid_o, bus.busy_o, bus.ready_o, bus.result_o, bus.rd_addr_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_op("after_reset", DIVU, 32'd50, 32'd5, 5'd7, 32'd10, 32);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
